// File: rtl/branch_history_table.sv
// Branch history table: 2-bit saturating-counter direction predictor for the
// fetch stage, trained by conditional jumps resolving in execute, plus
// running counts of resolved and mispredicted conditional jumps.
module branch_history_table #(
   parameter int unsigned IDX_W    = 4,
   parameter logic [1:0]  INIT_CTR = 2'b01
) (
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic [63:0] f_PC_i,
   input  logic [3:0]  f_icode_i,
   input  logic [3:0]  f_ifun_i,
   input  logic [63:0] f_valC_i,
   input  logic [63:0] f_valP_i,
   input  logic [63:0] E_PC_i,
   input  logic [3:0]  E_icode_i,
   input  logic [3:0]  E_ifun_i,
   input  logic        E_branch_taken_i,
   input  logic        e_Cnd_i,
   output logic [63:0] f_predPC_o,
   output logic        f_branch_taken_o,
   output logic [63:0] branch_cnt_o,
   output logic [63:0] mis_cnt_o
);

   localparam int         DEPTH      = 2 ** IDX_W;
   localparam logic [3:0] ICODE_JXX  = 4'd7;
   localparam logic [3:0] ICODE_CALL = 4'd8;
   localparam logic [3:0] IFUN_JMP   = 4'd0;

   logic [1:0]       ctr_q [DEPTH];
   logic [1:0]       ctr_d [DEPTH];
   logic [63:0]      branch_cnt_q, branch_cnt_d;
   logic [63:0]      mis_cnt_q, mis_cnt_d;
   logic [IDX_W-1:0] f_idx;
   logic [IDX_W-1:0] e_idx;
   logic             upd;
   logic             unused_pc_bits;

   // The table is direct-mapped on the low PC bits; the rest only aliases.
   assign f_idx          = f_PC_i[IDX_W-1:0];
   assign e_idx          = E_PC_i[IDX_W-1:0];
   assign unused_pc_bits = ^{f_PC_i[63:IDX_W], E_PC_i[63:IDX_W]};

   // Only conditional jumps train the table; jmp, call and bubbles do not.
   assign upd = (E_icode_i == ICODE_JXX) && (E_ifun_i != IFUN_JMP);

   assign branch_cnt_o = branch_cnt_q;
   assign mis_cnt_o    = mis_cnt_q;

   // Fetch prediction reads the registered table, so a same-cycle update is
   // only seen from the next cycle.
   always_comb begin
      // NOTE: every output gets a default first so no path infers a latch.
      f_branch_taken_o = 1'b0;
      f_predPC_o       = f_valP_i;
      if (f_icode_i == ICODE_JXX) begin
         if (f_ifun_i == IFUN_JMP) begin
            f_branch_taken_o = 1'b1;
            f_predPC_o       = f_valC_i;
         end else begin
            f_branch_taken_o = ctr_q[f_idx][1];
            f_predPC_o       = ctr_q[f_idx][1] ? f_valC_i : f_valP_i;
         end
      end else if (f_icode_i == ICODE_CALL) begin
         f_predPC_o = f_valC_i;
      end
   end

   // Next-state for the resolving conditional jump: saturating counter step
   // and statistic bumps.
   always_comb begin
      ctr_d        = ctr_q;
      branch_cnt_d = branch_cnt_q;
      mis_cnt_d    = mis_cnt_q;
      if (upd) begin
         if (e_Cnd_i) begin
            if (ctr_q[e_idx] != 2'b11) ctr_d[e_idx] = ctr_q[e_idx] + 2'd1;
         end else begin
            if (ctr_q[e_idx] != 2'b00) ctr_d[e_idx] = ctr_q[e_idx] - 2'd1;
         end
         branch_cnt_d = branch_cnt_q + 64'd1;
         if (e_Cnd_i != E_branch_taken_i) mis_cnt_d = mis_cnt_q + 64'd1;
      end
   end

   // State registers; reset restores the whole table to the weak initial bias.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         // NOTE: the counter array is reset entry by entry because predictions
         // are consumed straight out of reset and must never see X.
         for (int i = 0; i < DEPTH; i++) ctr_q[i] <= INIT_CTR;
         branch_cnt_q <= '0;
         mis_cnt_q    <= '0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values.
         ctr_q        <= ctr_d;
         branch_cnt_q <= branch_cnt_d;
         mis_cnt_q    <= mis_cnt_d;
      end
   end

endmodule

// File: tb/tb_branch_history_table.sv
// Directed bench for branch_history_table: a behavioural predictor model is
// compared against the DUT on every falling edge, and hand-computed literals
// pin the model at the interesting points of each scenario.
module tb_branch_history_table;

   localparam int DEPTH = 16;

   logic        clk_i = 1'b0;
   logic        rst_n_i;
   logic [63:0] f_PC_i, f_valC_i, f_valP_i, E_PC_i;
   logic [3:0]  f_icode_i, f_ifun_i, E_icode_i, E_ifun_i;
   logic        E_branch_taken_i, e_Cnd_i;
   logic [63:0] f_predPC_o, branch_cnt_o, mis_cnt_o;
   logic        f_branch_taken_o;

   int n_pass  = 0;
   int n_total = 0;
   bit cmp_en  = 1'b0;

   branch_history_table #(.IDX_W(4), .INIT_CTR(2'b01)) dut (
      .clk_i            (clk_i),
      .rst_n_i          (rst_n_i),
      .f_PC_i           (f_PC_i),
      .f_icode_i        (f_icode_i),
      .f_ifun_i         (f_ifun_i),
      .f_valC_i         (f_valC_i),
      .f_valP_i         (f_valP_i),
      .E_PC_i           (E_PC_i),
      .E_icode_i        (E_icode_i),
      .E_ifun_i         (E_ifun_i),
      .E_branch_taken_i (E_branch_taken_i),
      .e_Cnd_i          (e_Cnd_i),
      .f_predPC_o       (f_predPC_o),
      .f_branch_taken_o (f_branch_taken_o),
      .branch_cnt_o     (branch_cnt_o),
      .mis_cnt_o        (mis_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   // Model state: counter strength 0..3 per table slot, plain integer stats.
   int              m_ctr [DEPTH];
   longint unsigned m_branch, m_mis;
   logic            exp_taken;
   logic [63:0]     exp_pc;

   always @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         foreach (m_ctr[i]) m_ctr[i] <= 1;
         m_branch <= 0;
         m_mis    <= 0;
      end else if (E_icode_i == 4'd7 && E_ifun_i != 4'd0) begin
         if (e_Cnd_i) m_ctr[int'(E_PC_i % 64'(DEPTH))] <= (m_ctr[int'(E_PC_i % 64'(DEPTH))] >= 3) ? 3 : m_ctr[int'(E_PC_i % 64'(DEPTH))] + 1;
         else         m_ctr[int'(E_PC_i % 64'(DEPTH))] <= (m_ctr[int'(E_PC_i % 64'(DEPTH))] <= 0) ? 0 : m_ctr[int'(E_PC_i % 64'(DEPTH))] - 1;
         m_branch <= m_branch + 1;
         if (e_Cnd_i != E_branch_taken_i) m_mis <= m_mis + 1;
      end
   end

   always @(negedge clk_i) begin
      if (cmp_en) begin
         exp_taken = 1'b0;
         exp_pc    = f_valP_i;
         if (f_icode_i == 4'd7 && f_ifun_i == 4'd0) begin
            exp_taken = 1'b1;
            exp_pc    = f_valC_i;
         end else if (f_icode_i == 4'd7) begin
            exp_taken = (m_ctr[int'(f_PC_i % 64'(DEPTH))] >= 2);
            exp_pc    = exp_taken ? f_valC_i : f_valP_i;
         end else if (f_icode_i == 4'd8) begin
            exp_pc = f_valC_i;
         end
         check("model_pred_pc",    f_predPC_o,       exp_pc);
         check("model_pred_taken", f_branch_taken_o, exp_taken);
         check("model_branch_cnt", branch_cnt_o,     m_branch);
         check("model_mis_cnt",    mis_cnt_o,        m_mis);
      end
   end

   task automatic set_f(input logic [63:0] pc, input logic [3:0] icode, input logic [3:0] ifun,
                        input logic [63:0] valc, input logic [63:0] valp);
      f_PC_i = pc; f_icode_i = icode; f_ifun_i = ifun; f_valC_i = valc; f_valP_i = valp;
   endtask

   task automatic set_e(input logic [63:0] pc, input logic [3:0] icode, input logic [3:0] ifun,
                        input logic bt, input logic cnd);
      E_PC_i = pc; E_icode_i = icode; E_ifun_i = ifun; E_branch_taken_i = bt; e_Cnd_i = cnd;
   endtask

   // Advance to 2 time units after the next rising edge.
   task automatic tick();
      @(posedge clk_i);
      #2;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      rst_n_i = 1'b0;
      set_f(64'h20, 4'd7, 4'd1, 64'h100, 64'h29);
      set_e(64'h0, 4'd1, 4'd0, 1'b0, 1'b0);
      cmp_en = 1'b1;
      #3;
      check("reset_branch_cnt", branch_cnt_o, 64'd0);
      check("reset_mis_cnt", mis_cnt_o, 64'd0);
      check("reset_pred_pc", f_predPC_o, 64'h29);
      #9 rst_n_i = 1'b1;
      tick();

      // jle after reset: weakly not-taken, fall through.
      #1;
      check("jle_init_taken", f_branch_taken_o, 1'b0);
      check("jle_init_pc", f_predPC_o, 64'h29);

      // Two taken updates at 0x20 move the counter to strongly taken.
      set_e(64'h20, 4'd7, 4'd1, 1'b0, 1'b1);
      tick();
      set_e(64'h20, 4'd7, 4'd1, 1'b1, 1'b1);
      tick();
      set_e(64'h0, 4'd1, 4'd0, 1'b0, 1'b0);
      #1;
      check("trained_taken", f_branch_taken_o, 1'b1);
      check("trained_pc", f_predPC_o, 64'h100);
      check("trained_branch_cnt", branch_cnt_o, 64'd2);
      check("trained_mis_cnt", mis_cnt_o, 64'd1);

      // Third and fourth taken updates saturate; one not-taken still predicts taken.
      set_e(64'h20, 4'd7, 4'd1, 1'b1, 1'b1);
      tick();
      tick();
      set_e(64'h20, 4'd7, 4'd1, 1'b1, 1'b0);
      tick();
      set_e(64'h0, 4'd1, 4'd0, 1'b0, 1'b0);
      #1;
      check("top_sat_taken", f_branch_taken_o, 1'b1);
      check("top_sat_branch_cnt", branch_cnt_o, 64'd5);
      check("top_sat_mis_cnt", mis_cnt_o, 64'd2);

      // jmp and call predictions; jmp and call in execute touch no state.
      set_f(64'h0, 4'd7, 4'd0, 64'h40, 64'h9);
      set_e(64'h30, 4'd7, 4'd0, 1'b1, 1'b1);
      #1;
      check("jmp_pc", f_predPC_o, 64'h40);
      check("jmp_taken", f_branch_taken_o, 1'b1);
      tick();
      #1;
      check("jmp_exec_branch_cnt", branch_cnt_o, 64'd5);
      set_f(64'h0, 4'd8, 4'd0, 64'h80, 64'h9);
      set_e(64'h30, 4'd8, 4'd0, 1'b0, 1'b1);
      #1;
      check("call_pc", f_predPC_o, 64'h80);
      check("call_taken", f_branch_taken_o, 1'b0);
      tick();
      set_f(64'h5, 4'd9, 4'd0, 64'h80, 64'h9);
      set_e(64'h0, 4'd1, 4'd1, 1'b0, 1'b1);
      #1;
      check("ret_pc", f_predPC_o, 64'h9);
      check("call_exec_branch_cnt", branch_cnt_o, 64'd5);
      tick();

      // Bottom saturation at slot 3; fetch at 0x13 aliases to the same slot.
      set_e(64'h3, 4'd7, 4'd3, 1'b0, 1'b0);
      tick();
      tick();
      set_e(64'h3, 4'd7, 4'd3, 1'b0, 1'b1);
      tick();
      set_f(64'h13, 4'd7, 4'd3, 64'h300, 64'h1c);
      #1;
      check("bot_sat_weak", f_branch_taken_o, 1'b0);
      tick();
      set_e(64'h0, 4'd1, 4'd0, 1'b0, 1'b0);
      #1;
      check("bot_sat_taken", f_branch_taken_o, 1'b1);
      check("bot_sat_pc", f_predPC_o, 64'h300);
      check("bot_sat_branch_cnt", branch_cnt_o, 64'd9);
      check("bot_sat_mis_cnt", mis_cnt_o, 64'd4);

      // Asynchronous reset between edges with an update pending.
      set_f(64'h20, 4'd7, 4'd1, 64'h100, 64'h29);
      set_e(64'h20, 4'd7, 4'd1, 1'b0, 1'b0);
      #1;
      check("pre_reset_taken", f_branch_taken_o, 1'b1);
      rst_n_i = 1'b0;
      #1;
      check("async_rst_branch_cnt", branch_cnt_o, 64'd0);
      check("async_rst_mis_cnt", mis_cnt_o, 64'd0);
      check("async_rst_taken", f_branch_taken_o, 1'b0);
      check("async_rst_pc", f_predPC_o, 64'h29);
      @(posedge clk_i);
      #1;
      check("rst_held_branch_cnt", branch_cnt_o, 64'd0);
      @(negedge clk_i);
      #2 rst_n_i = 1'b1;
      tick();
      set_e(64'h0, 4'd1, 4'd0, 1'b0, 1'b0);
      #1;
      check("post_rst_branch_cnt", branch_cnt_o, 64'd1);
      check("post_rst_mis_cnt", mis_cnt_o, 64'd0);

      // Same-cycle fetch and update at slot 0 from the initial counter.
      rst_n_i = 1'b0;
      #1 rst_n_i = 1'b1;
      set_f(64'h0, 4'd7, 4'd2, 64'h200, 64'h9);
      set_e(64'h10, 4'd7, 4'd2, 1'b0, 1'b1);
      #1;
      check("bypass_same_cycle_taken", f_branch_taken_o, 1'b0);
      check("bypass_same_cycle_pc", f_predPC_o, 64'h9);
      tick();
      set_e(64'h0, 4'd1, 4'd0, 1'b0, 1'b0);
      #1;
      check("bypass_next_taken", f_branch_taken_o, 1'b1);
      check("bypass_next_pc", f_predPC_o, 64'h200);
      check("bypass_branch_cnt", branch_cnt_o, 64'd1);
      check("bypass_mis_cnt", mis_cnt_o, 64'd1);

      @(negedge clk_i);
      #1;
      cmp_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
